// File: rtl/dma_pkg.sv
// Shared constants for the single-channel DMA sequencer: bus widths,
// memory geometry, read latency and FSM state encodings.
package dma_pkg;

  localparam int DMA_ADDR_W = 8;
  localparam int DMA_DATA_W = 32;
  localparam int MEM_DEPTH  = 192;
  // Top word holds the memory's own free-slot counter; DMA must never touch it.
  localparam int RSVD_ADDR  = MEM_DEPTH - 1;
  // Memory registers its read data, so data trails the address by one clock.
  localparam int READ_LAT   = 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_RD      = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

endpackage

// File: rtl/dma_range_check.sv
// Combinational admission check for a copy request. Sums are one bit wider
// than the address so that end-of-block never wraps. An empty block is a
// legal no-op whatever its addresses are, but a full memory always refuses.
module dma_range_check
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W-1:0] i_count,
  input  logic              i_memfull,
  output logic              o_zero,
  output logic              o_err,
  output logic              o_ok
);

  localparam logic [ADDR_W:0] LAST_FREE = (ADDR_W+1)'(RSVD_ADDR - 1);

  logic [ADDR_W:0] w_src_last;
  logic [ADDR_W:0] w_dst_last;

  // Last word touched on each side, and the resulting accept/refuse flags.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_src_last = '0;
    w_dst_last = '0;
    o_zero     = 1'b0;
    o_err      = 1'b0;
    o_ok       = 1'b0;

    w_src_last = {1'b0, i_src} + {1'b0, i_count} - (ADDR_W+1)'(1);
    w_dst_last = {1'b0, i_dst} + {1'b0, i_count} - (ADDR_W+1)'(1);
    o_zero     = (i_count == '0);
    o_err      = i_memfull |
                 (!o_zero & ((w_src_last > LAST_FREE) | (w_dst_last > LAST_FREE)));
    o_ok       = !o_err & !o_zero;
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer. Copies a block of words src -> dst in
// ascending order over the shared memory bus after winning it from the CPU
// through hold_req/hold_ack. Each word is read, waited on, then written;
// a word in flight always completes before the bus can be given back.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [ADDR_W-1:0] i_count,
  input  logic              i_memfull,
  input  logic              i_hold_ack,
  output logic              o_hold_req,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_drive,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_remaining;
  logic [3:0]        r_lat_cnt;
  logic              r_hold_req;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_drive;

  logic w_zero;
  logic w_err;
  logic w_ok;

  dma_range_check #(
    .ADDR_W (ADDR_W)
  ) u_range_check (
    .i_src     (i_src_addr),
    .i_dst     (i_dst_addr),
    .i_count   (i_count),
    .i_memfull (i_memfull),
    .o_zero    (w_zero),
    .o_err     (w_err),
    .o_ok      (w_ok)
  );

  // Transfer FSM plus address/count/data registers; all outputs registered.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_lat_cnt   <= '0;
      r_hold_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_drive <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_err) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else if (w_zero) begin
              r_err  <= 1'b0;
              r_done <= 1'b1;
            end else if (w_ok) begin
              r_err       <= 1'b0;
              r_src       <= i_src_addr;
              r_dst       <= i_dst_addr;
              r_remaining <= i_count;
              r_busy      <= 1'b1;
              r_hold_req  <= 1'b1;
              r_state     <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (i_hold_ack) begin
            r_mem_addr  <= r_src;
            r_mem_wr    <= 1'b0;
            r_mem_drive <= 1'b0;
            r_state     <= ST_RD;
          end
        end

        ST_RD: begin
          r_lat_cnt <= '0;
          r_state   <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (r_lat_cnt == 4'(READ_LAT - 1)) begin
            r_mem_wdata <= i_mem_rdata;
            r_mem_addr  <= r_dst;
            r_mem_wr    <= 1'b1;
            r_mem_drive <= 1'b1;
            r_state     <= ST_WR;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end

        ST_WR: begin
          r_mem_wr    <= 1'b0;
          r_mem_drive <= 1'b0;
          r_src       <= r_src + ADDR_W'(1);
          r_dst       <= r_dst + ADDR_W'(1);
          r_remaining <= r_remaining - ADDR_W'(1);
          if (r_remaining == ADDR_W'(1)) begin
            r_hold_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_FIN;
          end else if (i_hold_ack) begin
            r_mem_addr <= r_src + ADDR_W'(1);
            r_state    <= ST_RD;
          end else begin
            // CPU took the bus back: keep requesting, wait in REQ.
            r_state <= ST_REQ;
          end
        end

        ST_FIN: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_hold_req  = r_hold_req;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_drive = r_mem_drive;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl with a 192x32 memory model whose read
// data is registered (one clock latency). Inputs change and outputs are
// sampled on the falling edge.
module tb_dma_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  count;
  logic        memfull;
  logic        hold_ack;
  logic        hold_req;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_drive;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:191];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  int          wr_cnt;
  int          hreq_cnt;
  int          drive_bad;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  dma_xfer_ctrl dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_src_addr  (src_addr),
    .i_dst_addr  (dst_addr),
    .i_count     (count),
    .i_memfull   (memfull),
    .i_hold_ack  (hold_ack),
    .o_hold_req  (hold_req),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_mem_wr    (mem_wr),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_drive (mem_drive),
    .i_mem_rdata (mem_rdata)
  );

  // Memory model: bench backdoor load, DMA write, registered read; bus monitors.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] = ld_data;
    end else if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
    if (hold_req) hreq_cnt = hreq_cnt + 1;
    if (mem_drive !== mem_wr) drive_bad = drive_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Drives a one-cycle start pulse; returns just after the sampling edge.
  task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    src_addr = s;
    dst_addr = d;
    count    = c;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // n = number of edges since (and including) the last sampling edge when done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int wr0;
  int hr0;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    wr_cnt    = 0;
    hreq_cnt  = 0;
    drive_bad = 0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    reset     = 1'b1;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    count     = '0;
    memfull   = 1'b0;
    hold_ack  = 1'b1;

    // Preload source words and destination markers while in reset.
    load(8'd0,   32'd8);
    load(8'd1,   32'd9);
    load(8'd2,   32'd12);
    load(8'd110, 32'h0000_0110);
    load(8'd10,  32'h1000_0001);
    load(8'd11,  32'h1000_0002);
    load(8'd12,  32'h1000_0003);
    load(8'd13,  32'h1000_0004);
    load(8'd14,  32'h1000_0005);
    load(8'd122, 32'hDEAD_0122);
    load(8'd20,  32'h0000_2020);
    load(8'd21,  32'h0000_2121);
    load(8'd141, 32'hDEAD_0141);
    load(8'd30,  32'h0000_3030);
    load(8'd40,  32'h0000_4040);
    load(8'd41,  32'h0000_4141);
    load(8'd170, 32'hDEAD_0170);

    check("rst_hold_req", hold_req, 1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_mem_wr",   mem_wr,   1'b0);
    check("rst_drive",    mem_drive, 1'b0);
    check("rst_addr",     mem_addr, 8'd0);
    check("rst_wdata",    mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: three-word copy 0 -> 100, bus already granted.
    do_start(8'd0, 8'd100, 8'd3);
    check("t1_hold_req_next", hold_req, 1'b1);
    check("t1_busy_next",     busy,     1'b1);
    wait_done(n);
    check("t1_latency", n, 11);
    check("t1_err", err, 1'b0);
    check("t1_busy_at_done", busy, 1'b0);
    check("t1_m100", mem[100], 32'd8);
    check("t1_m101", mem[101], 32'd9);
    check("t1_m102", mem[102], 32'd12);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);
    check("t1_hold_req_off", hold_req, 1'b0);

    // 2: count 0 is a no-op.
    hr0 = hreq_cnt;
    wr0 = wr_cnt;
    do_start(8'd5, 8'd110, 8'd0);
    check("t2_done", done, 1'b1);
    check("t2_err", err, 1'b0);
    @(negedge clk);
    check("t2_done_pulse", done, 1'b0);
    check("t2_no_hold_req", hreq_cnt - hr0, 0);
    check("t2_no_writes", wr_cnt - wr0, 0);
    check("t2_m110", mem[110], 32'h0000_0110);

    // 3: range touching the reserved word is refused; then memfull refuses.
    hr0 = hreq_cnt;
    wr0 = wr_cnt;
    do_start(8'd188, 8'd0, 8'd4);
    check("t3_done", done, 1'b1);
    check("t3_err", err, 1'b1);
    @(negedge clk);
    check("t3_done_pulse", done, 1'b0);
    check("t3_err_sticky", err, 1'b1);
    do_start(8'd0, 8'd190, 8'd2);
    check("t3_dst_err", err, 1'b1);
    memfull = 1'b1;
    do_start(8'd0, 8'd100, 8'd1);
    check("t3_memfull_done", done, 1'b1);
    check("t3_memfull_err", err, 1'b1);
    memfull = 1'b0;
    @(negedge clk);
    check("t3_no_hold_req", hreq_cnt - hr0, 0);
    check("t3_no_writes", wr_cnt - wr0, 0);

    // 4: five words 10 -> 120, bus reclaimed during word 2.
    do_start(8'd10, 8'd120, 8'd5);
    check("t4_err_cleared", err, 1'b0);
    repeat (5) @(negedge clk);
    hold_ack = 1'b0;
    @(negedge clk);
    check("t4_w2_wr", mem_wr, 1'b1);
    check("t4_w2_addr", mem_addr, 8'd121);
    @(negedge clk);
    check("t4_pause_wr", mem_wr, 1'b0);
    check("t4_pause_drive", mem_drive, 1'b0);
    check("t4_pause_hold_req", hold_req, 1'b1);
    check("t4_m121", mem[121], 32'h1000_0002);
    repeat (4) @(negedge clk);
    check("t4_still_paused_busy", busy, 1'b1);
    check("t4_still_paused_wr", mem_wr, 1'b0);
    check("t4_m122_untouched", mem[122], 32'hDEAD_0122);
    hold_ack = 1'b1;
    wait_done(n);
    check("t4_done", done, 1'b1);
    check("t4_m120", mem[120], 32'h1000_0001);
    check("t4_m122", mem[122], 32'h1000_0003);
    check("t4_m123", mem[123], 32'h1000_0004);
    check("t4_m124", mem[124], 32'h1000_0005);
    @(negedge clk);

    // 5: reset while writing word 1 of 20 -> 140, then a fresh copy.
    do_start(8'd20, 8'd140, 8'd2);
    repeat (3) @(negedge clk);
    check("t5_in_wr", mem_wr, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_hold_req", hold_req, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_drive", mem_drive, 1'b0);
    check("t5_rst_wr", mem_wr, 1'b0);
    check("t5_rst_addr", mem_addr, 8'd0);
    @(negedge clk);
    check("t5_m141_untouched", mem[141], 32'hDEAD_0141);
    do_start(8'd30, 8'd150, 8'd1);
    wait_done(n);
    check("t5_latency", n, 5);
    check("t5_m150", mem[150], 32'h0000_3030);
    @(negedge clk);

    // 6: starts while busy are ignored (one valid, one out of range).
    do_start(8'd40, 8'd160, 8'd2);
    repeat (2) @(negedge clk);
    do_start(8'd0, 8'd170, 8'd1);
    do_start(8'd189, 8'd0, 8'd10);
    wait_done(n);
    check("t6_latency", n, 4);
    check("t6_err", err, 1'b0);
    check("t6_m160", mem[160], 32'h0000_4040);
    check("t6_m161", mem[161], 32'h0000_4141);
    @(negedge clk);
    check("t6_m170_untouched", mem[170], 32'hDEAD_0170);
    check("t6_idle_busy", busy, 1'b0);

    check("drive_tracks_wr", drive_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
